// File: rtl/frame_sequencer_pkg.sv
// Shared state encoding and constants for the guided-filter frame pipeline.
package frame_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_FINISH = 2'd3
   } seq_state_t;

   // Frame geometry is consumed by the stages, not by the sequencer itself.
   localparam int FRAME_W      = 300;
   localparam int FRAME_H      = 210;
   localparam int FRAME_PIXELS = FRAME_W * FRAME_H;

   localparam int TIMEOUT_CYC_DEFAULT = 1048576;

endpackage

// File: rtl/frame_sequencer_ram_port_mux.sv
// N-to-1 selector handing the shared frame RAM port to the active stage.
// When i_en is low the port is parked at all-zero so nothing can write.
module frame_sequencer_ram_port_mux
   import frame_sequencer_pkg::*;
#(
   parameter int N      = 4,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 24,
   parameter int SEL_W  = (N > 1) ? $clog2(N) : 1
) (
   input  logic [SEL_W-1:0]    i_sel,
   input  logic                i_en,
   input  logic [N*ADDR_W-1:0] i_addr,
   input  logic [N-1:0]        i_wren,
   input  logic [N*DATA_W-1:0] i_wdata,
   output logic [ADDR_W-1:0]   o_addr,
   output logic                o_wren,
   output logic [DATA_W-1:0]   o_wdata
);

   logic [ADDR_W-1:0] w_addr  [N];
   logic [DATA_W-1:0] w_wdata [N];

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_unpack
         assign w_addr[gi]  = i_addr[gi*ADDR_W +: ADDR_W];
         assign w_wdata[gi] = i_wdata[gi*DATA_W +: DATA_W];
      end
   endgenerate

   assign o_addr  = i_en ? w_addr[i_sel]  : '0;
   assign o_wren  = i_en & i_wren[i_sel];
   assign o_wdata = i_en ? w_wdata[i_sel] : '0;

endmodule

// File: rtl/frame_sequencer.sv
// Frame scheduler: launches pipeline stages in order via ena/done pulses,
// routes the shared RAM port to the running stage and watches for hangs.
module frame_sequencer
   import frame_sequencer_pkg::*;
#(
   parameter int NUM_STAGES  = 4,
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 24,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
   input  logic                         iCLK,
   input  logic                         iRST,
   input  logic                         iSTART,
   output logic                         oBUSY,
   output logic                         oFRAME_DONE,
   output logic                         oERR,
   output logic [$clog2(NUM_STAGES)-1:0] oERR_STAGE,
   output logic [NUM_STAGES-1:0]        oSTAGE_ENA,
   input  logic [NUM_STAGES-1:0]        iSTAGE_DONE,
   input  logic [NUM_STAGES*ADDR_W-1:0] iSTAGE_ADDR,
   input  logic [NUM_STAGES-1:0]        iSTAGE_WREN,
   input  logic [NUM_STAGES*DATA_W-1:0] iSTAGE_WDATA,
   output logic [ADDR_W-1:0]            oRAM_ADDR,
   output logic                         oRAM_WREN,
   output logic [DATA_W-1:0]            oRAM_WDATA,
   input  logic [DATA_W-1:0]            iRAM_RDATA,
   output logic [DATA_W-1:0]            oSTAGE_RDATA
);

   localparam int IDX_W = $clog2(NUM_STAGES);
   localparam int WD_W  = $clog2(TIMEOUT_CYC) + 1;

   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_STAGES - 1);
   localparam logic [WD_W-1:0]       WD_LAST  = WD_W'(TIMEOUT_CYC - 2);
   localparam logic [WD_W-1:0]       WD_SAT   = '1;
   localparam logic [NUM_STAGES-1:0] ENA_ONE  = NUM_STAGES'(1);

   seq_state_t            r_state;
   logic [IDX_W-1:0]      r_idx;
   logic [WD_W-1:0]       r_wd;
   logic                  r_busy;
   logic                  r_frame_done;
   logic                  r_err;
   logic [IDX_W-1:0]      r_err_stage;
   logic [NUM_STAGES-1:0] r_stage_ena;
   logic                  w_active;

   // The watchdog is zero after the launch cycle and counts one per WAIT
   // cycle, so the edge that makes it reach TIMEOUT_CYC-1 is the timeout edge.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_state      <= ST_IDLE;
         r_idx        <= '0;
         r_wd         <= '0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_err        <= 1'b0;
         r_err_stage  <= '0;
         r_stage_ena  <= '0;
      end else begin
         r_stage_ena  <= '0;
         r_frame_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (iSTART) begin
                  r_state     <= ST_LAUNCH;
                  r_idx       <= '0;
                  r_err       <= 1'b0;
                  r_err_stage <= '0;
                  r_busy      <= 1'b1;
                  r_stage_ena <= ENA_ONE;
               end
            end
            ST_LAUNCH: begin
               r_wd    <= '0;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (r_wd != WD_SAT) r_wd <= r_wd + 1'b1;
               if (iSTAGE_DONE[r_idx]) begin
                  if (r_idx == LAST_IDX) begin
                     r_state      <= ST_FINISH;
                     r_frame_done <= 1'b1;
                     r_busy       <= 1'b0;
                  end else begin
                     r_idx       <= r_idx + 1'b1;
                     r_state     <= ST_LAUNCH;
                     r_stage_ena <= ENA_ONE << (r_idx + 1'b1);
                  end
               end else if (r_wd >= WD_LAST) begin
                  r_state     <= ST_IDLE;
                  r_err       <= 1'b1;
                  r_err_stage <= r_idx;
                  r_busy      <= 1'b0;
               end
            end
            ST_FINISH: r_state <= ST_IDLE;
            default:   r_state <= ST_IDLE;
         endcase
      end
   end

   assign w_active = (r_state != ST_IDLE);

   frame_sequencer_ram_port_mux #(
      .N      (NUM_STAGES),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .SEL_W  (IDX_W)
   ) u_ram_mux (
      .i_sel   (r_idx),
      .i_en    (w_active),
      .i_addr  (iSTAGE_ADDR),
      .i_wren  (iSTAGE_WREN),
      .i_wdata (iSTAGE_WDATA),
      .o_addr  (oRAM_ADDR),
      .o_wren  (oRAM_WREN),
      .o_wdata (oRAM_WDATA)
   );

   assign oBUSY        = r_busy;
   assign oFRAME_DONE  = r_frame_done;
   assign oERR         = r_err;
   assign oERR_STAGE   = r_err_stage;
   assign oSTAGE_ENA   = r_stage_ena;
   assign oSTAGE_RDATA = iRAM_RDATA;

endmodule
